// File: rtl/env_adsr_if.sv
// Control/status bundle between the tracker/sequencer side and one ADSR envelope channel.
interface env_adsr_if #(
  parameter int RATE_W = 4
);
  logic              gate;
  logic [RATE_W-1:0] attack_rate;
  logic [RATE_W-1:0] decay_rate;
  logic [5:0]        sustain_level;
  logic [RATE_W-1:0] release_rate;
  logic [5:0]        vol;
  logic [2:0]        env_state;
  logic              env_active;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate,
    input  vol, env_state, env_active
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate,
    output vol, env_state, env_active
  );
endinterface

// File: rtl/env_adsr.sv
// Per-channel ADSR envelope generator producing a 0..63 amplitude for the DDS vol input.
// Optional macro ENV_EXP_RELEASE_EN: release step = max(1, vol>>3) instead of linear 1.
module env_adsr #(
  parameter int TICK_DIV = 4800,
  parameter int RATE_W   = 4
) (
  input logic       clk,
  input logic       rst_active_high,
  env_adsr_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

`ifdef ENV_EXP_RELEASE_EN
  localparam bit EXP_RELEASE = 1'b1;
`else
  localparam bit EXP_RELEASE = 1'b0;
`endif

  // Release decrement: vol/8 approximates an exponential tail, never less than one.
  function automatic logic [5:0] release_dec(input logic [5:0] v);
    if (EXP_RELEASE && (v[5:3] != 3'd0)) begin
      return {3'b000, v[5:3]};
    end else begin
      return 6'd1;
    end
  endfunction

  env_state_t        state_r;
  env_state_t        state_nxt_s;
  logic [5:0]        vol_r;
  logic [5:0]        vol_nxt_s;
  logic [5:0]        rel_dec_s;
  logic              gate_d_r;
  logic [PRESC_W-1:0] presc_r;
  logic [RATE_W-1:0] rate_cnt_r;
  logic [RATE_W-1:0] cur_rate_s;
  logic              rise_s;
  logic              fall_s;
  logic              tick_s;
  logic              step_s;
  logic              restart_s;

  assign rise_s    = bus.gate & ~gate_d_r;
  assign fall_s    = ~bus.gate & gate_d_r;
  assign tick_s    = (presc_r == PRESC_MAX);
  assign step_s    = tick_s & (rate_cnt_r == cur_rate_s);
  assign rel_dec_s = release_dec(vol_r);
  assign restart_s = rise_s | (state_nxt_s != state_r);

  // Select the live rate of the current stage.
  always_comb begin
    cur_rate_s = bus.decay_rate;
    case (state_r)
      ST_ATTACK:  cur_rate_s = bus.attack_rate;
      ST_DECAY:   cur_rate_s = bus.decay_rate;
      ST_RELEASE: cur_rate_s = bus.release_rate;
      default:    cur_rate_s = bus.decay_rate;
    endcase
  end

  // Next-state and next-volume logic; gate edges override stage stepping.
  always_comb begin
    state_nxt_s = state_r;
    vol_nxt_s   = vol_r;
    if (rise_s) begin
      state_nxt_s = ST_ATTACK;
    end else if (fall_s && ((state_r == ST_ATTACK) || (state_r == ST_DECAY) ||
                            (state_r == ST_SUSTAIN))) begin
      state_nxt_s = ST_RELEASE;
    end else begin
      case (state_r)
        ST_ATTACK: begin
          if (step_s) begin
            if (vol_r == 6'd63) begin
              state_nxt_s = ST_DECAY;
            end else begin
              vol_nxt_s = vol_r + 6'd1;
              if (vol_r == 6'd62) begin
                state_nxt_s = ST_DECAY;
              end else begin
                state_nxt_s = ST_ATTACK;
              end
            end
          end else begin
            state_nxt_s = ST_ATTACK;
          end
        end
        ST_DECAY: begin
          if (step_s) begin
            if (vol_r > bus.sustain_level) begin
              vol_nxt_s = vol_r - 6'd1;
              if ((vol_r - 6'd1) <= bus.sustain_level) begin
                state_nxt_s = ST_SUSTAIN;
              end else begin
                state_nxt_s = ST_DECAY;
              end
            end else begin
              state_nxt_s = ST_SUSTAIN;
            end
          end else begin
            state_nxt_s = ST_DECAY;
          end
        end
        ST_SUSTAIN: begin
          state_nxt_s = ST_SUSTAIN;
        end
        ST_RELEASE: begin
          if (step_s) begin
            if (vol_r > rel_dec_s) begin
              vol_nxt_s = vol_r - rel_dec_s;
            end else begin
              vol_nxt_s   = 6'd0;
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_RELEASE;
          end
        end
        ST_IDLE: begin
          vol_nxt_s = 6'd0;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          vol_nxt_s   = 6'd0;
        end
      endcase
    end
  end

  // State, volume, edge-detect and rate-timing registers.
  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      state_r    <= ST_IDLE;
      vol_r      <= 6'd0;
      gate_d_r   <= 1'b0;
      presc_r    <= '0;
      rate_cnt_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      vol_r    <= vol_nxt_s;
      gate_d_r <= bus.gate;
      if (restart_s) begin
        presc_r    <= '0;
        rate_cnt_r <= '0;
      end else begin
        presc_r <= tick_s ? '0 : (presc_r + {{(PRESC_W-1){1'b0}}, 1'b1});
        if (step_s) begin
          rate_cnt_r <= '0;
        end else if (tick_s) begin
          rate_cnt_r <= rate_cnt_r + {{(RATE_W-1){1'b0}}, 1'b1};
        end else begin
          rate_cnt_r <= rate_cnt_r;
        end
      end
    end
  end

  assign bus.vol        = vol_r;
  assign bus.env_state  = state_r;
  assign bus.env_active = (state_r != ST_IDLE);

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr: cycle model of the envelope rules plus literal spot checks.
module tb_env_adsr;
  localparam int TD = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  bit   chk_en;

  env_adsr_if #(.RATE_W(4)) bus ();

  env_adsr #(.TICK_DIV(TD), .RATE_W(4)) dut (
    .clk             (clk),
    .rst_active_high (rst),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Envelope model: one elapsed-cycle counter per stage, step when it spans TICK_DIV*(rate+1).
  int m_state, m_vol, m_cnt, m_rate, m_prev, m_dec;
  bit m_gate_d, m_rise, m_fall, m_step;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_vol = 0; m_cnt = 0; m_gate_d = 0;
    end else begin
      m_rise = bus.gate && !m_gate_d;
      m_fall = !bus.gate && m_gate_d;
      m_prev = m_state;
      m_rate = (m_state == 1) ? int'(bus.attack_rate) :
               (m_state == 2) ? int'(bus.decay_rate) : int'(bus.release_rate);
      m_step = (m_state == 1 || m_state == 2 || m_state == 4) && (m_cnt == TD * (m_rate + 1) - 1);
      m_cnt  = m_step ? 0 : m_cnt + 1;
      if (m_rise) m_state = 1;
      else if (m_fall && m_state >= 1 && m_state <= 3) m_state = 4;
      else if (m_step) begin
        if (m_state == 1) begin
          if (m_vol < 63) m_vol++;
          if (m_vol == 63) m_state = 2;
        end else if (m_state == 2) begin
          if (m_vol > int'(bus.sustain_level)) m_vol--;
          if (m_vol <= int'(bus.sustain_level)) m_state = 3;
        end else begin
`ifdef ENV_EXP_RELEASE_EN
          m_dec = (m_vol / 8 > 0) ? m_vol / 8 : 1;
`else
          m_dec = 1;
`endif
          m_vol = (m_vol > m_dec) ? m_vol - m_dec : 0;
          if (m_vol == 0) m_state = 0;
        end
      end
      if (m_rise || m_state != m_prev) m_cnt = 0;
      m_gate_d = bus.gate;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_vol", int'(bus.vol), m_vol);
      chk("cmp_state", int'(bus.env_state), m_state);
      chk("cmp_active", int'(bus.env_active), (m_state != 0) ? 1 : 0);
    end
  end

  task automatic lit(input string name, input int vol_exp, input int st_exp);
    chk({name, "_vol"}, int'(bus.vol), vol_exp);
    chk({name, "_state"}, int'(bus.env_state), st_exp);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; chk_en = 1'b0; n_checks = 0; n_err = 0;
    bus.gate = 1'b1; bus.attack_rate = 4'd0; bus.decay_rate = 4'd1;
    bus.sustain_level = 6'd40; bus.release_rate = 4'd0;
    @(negedge clk); chk_en = 1'b1;
    repeat (2) @(negedge clk);
    lit("reset", 0, 0);
    chk("reset_active", int'(bus.env_active), 0);
    rst = 1'b0;
    @(negedge clk); lit("rise_after_reset", 0, 1);
    chk("model_pin_attack", m_state, 1);
    repeat (3) @(negedge clk); lit("attack_pre", 0, 1);
    @(negedge clk); lit("attack_first", 1, 1);
    repeat (247) @(negedge clk); lit("attack_62", 62, 1);
    @(negedge clk); lit("attack_top", 63, 2);
    repeat (183) @(negedge clk); lit("decay_41", 41, 2);
    @(negedge clk); lit("decay_sustain", 40, 3);
    chk("model_pin_sustain", m_vol, 40);
    bus.sustain_level = 6'd20;
    repeat (1000) @(negedge clk); lit("sustain_hold", 40, 3);
    bus.gate = 1'b0;
    @(negedge clk); lit("release_entry", 40, 4);
`ifndef ENV_EXP_RELEASE_EN
    repeat (159) @(negedge clk); lit("release_1", 1, 4);
    @(negedge clk); lit("release_idle", 0, 0);
`else
    repeat (160) @(negedge clk); lit("release_idle", 0, 0);
`endif
    // Retrigger from the middle of a release.
    bus.sustain_level = 6'd40; bus.gate = 1'b1;
    @(negedge clk); lit("attack2_entry", 0, 1);
    repeat (120) @(negedge clk); lit("attack2_30", 30, 1);
    bus.gate = 1'b0;
    @(negedge clk); lit("rel2_entry", 30, 4);
    repeat (9) @(negedge clk);
    bus.gate = 1'b1;
    @(negedge clk);
`ifndef ENV_EXP_RELEASE_EN
    lit("retrig_entry", 28, 1);
    repeat (3) @(negedge clk); lit("retrig_hold", 28, 1);
    @(negedge clk); lit("retrig_step", 29, 1);
`else
    lit("retrig_entry", 24, 1);
    repeat (4) @(negedge clk); lit("retrig_step", 25, 1);
`endif
    // Gate toggling faster than a tick, then let the model follow the settle.
    for (int i = 0; i < 3; i++) begin
      bus.gate = 1'b0; @(negedge clk);
      bus.gate = 1'b1; @(negedge clk);
    end
    repeat (500) @(negedge clk); lit("settle_sustain", 40, 3);
    // Mid-envelope reset with gate held high.
    bus.gate = 1'b0; repeat (20) @(negedge clk);
    bus.gate = 1'b1; repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); lit("mid_reset", 0, 0);
    rst = 1'b0; bus.sustain_level = 6'd63;
    @(negedge clk); lit("post_reset_rise", 0, 1);
    repeat (252) @(negedge clk); lit("attack3_top", 63, 2);
    repeat (8) @(negedge clk); lit("decay_no_dec", 63, 3);
    bus.gate = 1'b0; @(negedge clk); lit("short_release", 63, 4);
    bus.gate = 1'b1; @(negedge clk); lit("attack_at_63", 63, 1);
    repeat (3) @(negedge clk); lit("attack_63_hold", 63, 1);
    @(negedge clk); lit("attack_63_to_decay", 63, 2);
    repeat (8) @(negedge clk); lit("sustain_63", 63, 3);
    // Release from the top: linear or exponential sequence.
    bus.gate = 1'b0; @(negedge clk); lit("rel3_entry", 63, 4);
`ifdef ENV_EXP_RELEASE_EN
    repeat (4) @(negedge clk); lit("exp_56", 56, 4);
    repeat (4) @(negedge clk); lit("exp_49", 49, 4);
    repeat (4) @(negedge clk); lit("exp_43", 43, 4);
`else
    repeat (4) @(negedge clk); lit("lin_62", 62, 4);
    repeat (4) @(negedge clk); lit("lin_61", 61, 4);
    repeat (4) @(negedge clk); lit("lin_60", 60, 4);
`endif
    repeat (300) @(negedge clk); lit("rel3_idle", 0, 0);
    // Release entered at vol 0 goes idle at its first step.
    bus.gate = 1'b1; @(negedge clk); lit("zero_attack", 0, 1);
    bus.gate = 1'b0; @(negedge clk); lit("zero_release", 0, 4);
    repeat (3) @(negedge clk); lit("zero_release_hold", 0, 4);
    @(negedge clk); lit("zero_release_idle", 0, 0);
    repeat (10) @(negedge clk); lit("idle_hold", 0, 0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/env_adsr.md
Name: env_adsr

Overview:
- Per-channel ADSR envelope generator driving the 6-bit `vol` input of the DDS oscillator stage (saw/square/tri), directly upstream of it.
- Converts a note gate from the sequencer into a time-varying 0..63 amplitude.
- Rates and sustain level are supplied per channel by the tracker control registers.

Parameters:
- TICK_DIV, 4800, clocks per envelope tick (prescaler period); must be >= 2.
- RATE_W, 4, width of attack/decay/release rate fields.

Ports:
- clk  in  1  system clock
- rst_active_high  in  1  synchronous active-high reset
- gate  in  1  note on (1) / note off (0) from sequencer
- attack_rate  in  RATE_W  ticks per attack step minus 1
- decay_rate  in  RATE_W  ticks per decay step minus 1
- sustain_level  in  6  sustain volume 0..63
- release_rate  in  RATE_W  ticks per release step minus 1
- vol  out  6  envelope amplitude to DDS `vol` input
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- env_active  out  1  high when env_state != IDLE

Behaviour:
- All logic is clocked on posedge clk. Reset is synchronous: vol=0, env_state=IDLE, env_active=0, gate_d=0, prescaler=0, rate_cnt=0.
- Edge detect uses a registered copy gate_d: rise = gate & ~gate_d; fall = ~gate & gate_d.
- Prescaler counts 0..TICK_DIV-1; tick = (prescaler == TICK_DIV-1).
- Rate counter:
  - rate_cnt increments on tick.
  - step = tick & (rate_cnt == current stage rate); rate_cnt clears on step.
  - Rates are sampled live each cycle.
- On any state transition, prescaler and rate_cnt clear. The first step in a state therefore occurs exactly TICK_DIV*(rate+1) cycles after the state is entered.
- Transitions, priority top-down:
  - rise (any state) -> ATTACK; vol unchanged (retrigger from current level, no click).
  - fall in ATTACK/DECAY/SUSTAIN -> RELEASE; vol unchanged.
  - ATTACK: on step, vol+1. When the new vol == 63, go to DECAY on the same edge. Entering ATTACK with vol already 63 -> first step goes to DECAY, vol stays 63.
  - DECAY: on step, if vol > sustain_level then vol-1. If the resulting vol <= sustain_level, go to SUSTAIN on the same edge. If vol <= sustain_level at the step, go to SUSTAIN with no decrement.
  - SUSTAIN: vol held; no steps. A sustain_level change while in SUSTAIN is ignored until the next DECAY.
  - RELEASE: on step, vol-1, saturating at 0. When the new vol == 0, go to IDLE on the same edge. Entering RELEASE with vol=0 -> go to IDLE at the first step.
  - IDLE: vol=0, held; only rise leaves IDLE.
- Outputs are registered: vol/env_state change one clock after the causing edge/step condition. env_active is derived from the registered env_state.
- Arithmetic: vol never wraps. Attack saturates at 63, decay/release at 0.
- gate toggling faster than a tick: each rise/fall acts immediately; the rate timing restarts.
- Reset mid-envelope returns to IDLE with vol=0 on the next clock, regardless of gate. A gate held high through reset release produces no rise until gate_d has been 0 (gate_d resets to 0, so a held-high gate DOES produce a rise on the first post-reset cycle).

Optional Feature:
- Macro: ENV_EXP_RELEASE_EN.
- Defined: release step size = max(1, vol>>3), saturating at 0, approximating an exponential tail. Example: vol 63 -> 56 -> 49 -> 43...
- Undefined: linear release, step size 1.
- Attack and decay are linear in both cases.

Test Plan:
- Reset held 3 cycles with gate=1 -> vol=0, env_state=0, env_active=0; after release, a rise is seen and env_state=1 next cycle.
- TICK_DIV=4, attack_rate=0, gate 0->1 -> vol=1 exactly 4 cycles after env_state=1; vol=63 and env_state=2 at 252 cycles.
- decay_rate=1, sustain_level=40 after full attack -> vol steps down by 1 every 8 cycles; env_state=3 on the edge vol becomes 40; vol holds 40 for 1000 cycles.
- gate 1->0 in SUSTAIN with vol=40, release_rate=0 -> env_state=4; vol=0 and env_state=0 after 160 cycles (linear).
- Retrigger: gate falls at vol=30 in RELEASE, rises 10 cycles later -> env_state=1 with vol continuing from its current value (no drop to 0), vol increments after 4 cycles.
- ENV_EXP_RELEASE_EN defined, release from vol=63, rate 0 -> vol sequence 63,56,49,43,38,34,30,... reaches 0, IDLE with no underflow.
